pr_timer: RTL

//  Memory-mapped down-counting timer; slave on the processor-side peripheral bus (Pr*) driven by the MEM stage.

---
 rtl/pr_timer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pr_timer.sv
// Memory-mapped down-counting timer on the Pr* peripheral bus: CTRL/PRESET/COUNT/PSC window with level IRQ.
// Optional prescaler enabled by defining PR_TIMER_PRESCALE_EN; otherwise COUNT steps every cycle.
`timescale 1ns/1ps
module pr_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h7f00,
  parameter int          PSC_W     = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWData,
  input  logic [3:0]  PrMask,
  input  logic        PrWrite,
  output logic [31:0] PrRData,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} stateT;

  stateT       state, stateNext;
  logic [3:0]  ctrl;
  logic [31:0] preset, count, countNext, pscRead;
  logic        irqFlag, setIrq, clrEn, tick, hit, wrEn;
  logic [1:0]  regSel;
  logic        unusedAddr;

  assign hit        = (PrAddr[31:4] == BASE_ADDR[31:4]);
  assign wrEn       = PrWrite & hit;
  assign regSel     = PrAddr[3:2];
  assign unusedAddr = ^PrAddr[1:0];
  assign IRQ        = irqFlag & ctrl[3];

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                             input logic [3:0] mask);
    logic [31:0] r;
    r = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = newVal[8*i +: 8];
    end
    return r;
  endfunction

`ifdef PR_TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc, prescaler, prescalerNext;
  logic [31:0]      pscMerged;

  assign pscMerged = mergeLanes(32'(psc), PrWData, PrMask);
  assign pscRead   = 32'(psc);
  assign tick      = (prescaler == '0);

  // The prescaler only runs while actively counting; a PSC write lands at the next reload.
  always_comb begin
    prescalerNext = prescaler;
    if (state == LOAD) begin
      prescalerNext = psc;
    end else if (state == CNT && ctrl[0]) begin
      prescalerNext = tick ? psc : prescaler - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      psc       <= '0;
      prescaler <= '0;
    end else begin
      prescaler <= prescalerNext;
      if (wrEn && regSel == 2'd3) psc <= pscMerged[PSC_W-1:0];
    end
  end
`else
  logic [PSC_W-1:0] unusedPsc;
  assign unusedPsc = '0;
  assign pscRead   = '0;
  assign tick      = 1'b1;
`endif

  always_comb begin
    stateNext = state;
    countNext = count;
    setIrq    = 1'b0;
    clrEn     = 1'b0;
    case (state)
      IDLE: if (ctrl[0]) stateNext = LOAD;
      LOAD: begin
        countNext = preset;
        stateNext = CNT;
      end
      CNT: begin
        if (!ctrl[0]) begin
          stateNext = IDLE;
        end else if (tick) begin
          // Floor at zero: PRESET=0 expires exactly like PRESET=1.
          if (count > 32'd1) begin
            countNext = count - 32'd1;
          end else begin
            countNext = '0;
            stateNext = INT;
          end
        end
      end
      INT: begin
        setIrq = 1'b1;
        if (ctrl[2:1] == 2'b01) begin
          stateNext = LOAD;
        end else begin
          clrEn     = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // A bus write to CTRL beats the FSM's one-shot EN clear and its IRQ set.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      irqFlag <= 1'b0;
    end else begin
      state <= stateNext;
      count <= countNext;
      if (wrEn && regSel == 2'd0 && PrMask[0]) begin
        ctrl <= PrWData[3:0];
      end else if (clrEn) begin
        ctrl[0] <= 1'b0;
      end
      if (wrEn && regSel == 2'd0) begin
        irqFlag <= 1'b0;
      end else if (setIrq) begin
        irqFlag <= 1'b1;
      end
      if (wrEn && regSel == 2'd1) preset <= mergeLanes(preset, PrWData, PrMask);
    end
  end

  always_comb begin
    PrRData = '0;
    if (hit) begin
      case (regSel)
        2'd0:    PrRData = {28'b0, ctrl};
        2'd1:    PrRData = preset;
        2'd2:    PrRData = count;
        default: PrRData = pscRead;
      endcase
    end
  end

endmodule
